// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: frame deserialiser, 3-byte packet FSM, clamped cursor.
// Define MOUSE_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_mouse_tracker #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        lmb,
  output logic        mmb,
  output logic        rmb,
  output logic [15:0] mouse_x,
  output logic [15:0] mouse_y,
  output logic        packet_valid,
  output logic        frame_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
  localparam logic signed [17:0] XM = 18'(X_MAX);
  localparam logic signed [17:0] YM = 18'(Y_MAX);

  typedef enum logic [1:0] {
    WAIT_B0, WAIT_B1, WAIT_B2, UPDATE
  } state_e;

  logic [1:0]    pc_q, pd_q;
  logic          pc_prev_q;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef MOUSE_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif
  logic          fall, din, par_ok;
  logic          byte_rdy, rx_err, tmo_hit;
  state_e        state_q, state_d;
  logic [2:0]    btn_raw_q;
  logic          xs_q, ys_q, xo_q, yo_q;
  logic [7:0]    b1_q, b2_q;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [2:0]    btn_q;
  logic          pv_q, fe_q, upd;
  logic signed [17:0] dx, dy, nx, ny;

  assign fall = pc_prev_q & ~pc_q[1];
  assign din  = pd_q[1];

`ifdef MOUSE_PARITY_CHECK_EN
  assign par_ok = ^{sh_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= 2'b11;
      pd_q      <= 2'b11;
      pc_prev_q <= 1'b1;
      idx_q     <= '0;
      sh_q      <= '0;
      tmo_q     <= '0;
`ifdef MOUSE_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      pc_q      <= {pc_q[0], ps2_clk};
      pd_q      <= {pd_q[0], ps2_data};
      pc_prev_q <= pc_q[1];
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      tmo_q     <= tmo_d;
`ifdef MOUSE_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    idx_d    = idx_q;
    sh_d     = sh_q;
    tmo_d    = tmo_q;
`ifdef MOUSE_PARITY_CHECK_EN
    par_d    = par_q;
`endif
    byte_rdy = 1'b0;
    rx_err   = 1'b0;
    tmo_hit  = 1'b0;
    if (fall) begin
      tmo_d = '0;
      unique case (1'b1)
        (idx_q == 4'd0): if (!din) idx_d = 4'd1;
        (idx_q == 4'd9): begin
`ifdef MOUSE_PARITY_CHECK_EN
          par_d = din;
`endif
          idx_d = 4'd10;
        end
        (idx_q == 4'd10): begin
          idx_d = 4'd0;
          if (din && par_ok) byte_rdy = 1'b1;
          else               rx_err   = 1'b1;
        end
        default: begin
          sh_d  = {din, sh_q[7:1]};
          idx_d = idx_q + 4'd1;
        end
      endcase
    end else if (idx_q != 4'd0) begin
      // a stalled frame is abandoned silently
      if (tmo_q == TMO) begin
        tmo_hit = 1'b1;
        idx_d   = 4'd0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_B0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UPDATE:  state_d = WAIT_B0;
      WAIT_B0: if (byte_rdy && sh_q[3]) state_d = WAIT_B1;
      WAIT_B1: begin
        if (rx_err || tmo_hit) state_d = WAIT_B0;
        else if (byte_rdy)     state_d = WAIT_B2;
      end
      WAIT_B2: begin
        if (rx_err || tmo_hit) state_d = WAIT_B0;
        else if (byte_rdy)     state_d = UPDATE;
      end
      default: state_d = WAIT_B0;
    endcase
  end

  always_comb begin
    upd = (state_q == UPDATE);
    dx  = xo_q ? '0 : {{10{xs_q}}, b1_q};
    dy  = yo_q ? '0 : {{10{ys_q}}, b2_q};
    nx  = $signed({2'b00, x_q}) + dx;
    ny  = $signed({2'b00, y_q}) - dy;
    x_d = x_q;
    y_d = y_q;
    if (upd) begin
      if (nx[17])       x_d = '0;
      else if (nx > XM) x_d = 16'(X_MAX);
      else              x_d = nx[15:0];
      if (ny[17])       y_d = '0;
      else if (ny > YM) y_d = 16'(Y_MAX);
      else              y_d = ny[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_raw_q <= '0;
      xs_q      <= 1'b0;
      ys_q      <= 1'b0;
      xo_q      <= 1'b0;
      yo_q      <= 1'b0;
      b1_q      <= '0;
      b2_q      <= '0;
      x_q       <= 16'(X_INIT);
      y_q       <= 16'(Y_INIT);
      btn_q     <= '0;
      pv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      if (byte_rdy && state_q == WAIT_B0 && sh_q[3]) begin
        btn_raw_q <= sh_q[2:0];
        xs_q      <= sh_q[4];
        ys_q      <= sh_q[5];
        xo_q      <= sh_q[6];
        yo_q      <= sh_q[7];
      end
      if (byte_rdy && state_q == WAIT_B1) b1_q <= sh_q;
      if (byte_rdy && state_q == WAIT_B2) b2_q <= sh_q;
      x_q  <= x_d;
      y_q  <= y_d;
      if (upd) btn_q <= btn_raw_q;
      pv_q <= upd;
      fe_q <= rx_err;
    end
  end

  assign lmb          = btn_q[0];
  assign rmb          = btn_q[1];
  assign mmb          = btn_q[2];
  assign mouse_x      = x_q;
  assign mouse_y      = y_q;
  assign packet_valid = pv_q;
  assign frame_error  = fe_q;
endmodule
